// File: rtl/alu_command_sequencer_if.sv
// rtl/alu_command_sequencer_if.sv - program-store, run-control and ALU command bus of the command sequencer
interface alu_command_sequencer_if #(
    parameter int ADDR_W    = 4,
    parameter int MAX_RETRY = 3
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_waddr;
    logic [11:0]       prog_wdata;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic [31:0]       y;
    logic              O;
    logic              C;
    logic              Z;
    logic              N;
    logic [11:0]       command;
    logic              syscall;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       last_y;
    logic [3:0]        last_flags;
    logic              cas_fail;
    logic [RW-1:0]     retry_cnt;

    modport master (
        input  prog_we, prog_waddr, prog_wdata, prog_len, start, y, O, C, Z, N,
        output command, syscall, busy, done, pc, last_y, last_flags, cas_fail, retry_cnt
    );

    modport slave (
        output prog_we, prog_waddr, prog_wdata, prog_len, start, y, O, C, Z, N,
        input  command, syscall, busy, done, pc, last_y, last_flags, cas_fail, retry_cnt
    );
endinterface

// File: rtl/alu_command_sequencer.sv
// rtl/alu_command_sequencer.sv - issues stored ALU commands with syscall strobes and CAS retry
module alu_command_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int ISSUE_GAP  = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_command_sequencer_if.master bus
);
    localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int IDX_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int GW    = $clog2(ISSUE_GAP + 1);

    localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(PROG_DEPTH);
    localparam logic [RW-1:0]   RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [GW-1:0]   GAP_V     = GW'(ISSUE_GAP);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]        state;
    logic [11:0]       mem [PROG_DEPTH];
    logic [11:0]       cmd_hold;
    logic [ADDR_W:0]   len_q;
    logic [GW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] pc_q;
    logic [RW-1:0]     retry_q;
    logic              cas_fail_q;
    logic [31:0]       last_y_q;
    logic [3:0]        flags_q;

    logic [11:0]       cur_cmd;
    logic [ADDR_W:0]   len_clamped;
    logic              last_slot;
    logic              cas_miss;
    logic              write_ok;

    assign cur_cmd     = mem[pc_q[IDX_W-1:0]];
    assign len_clamped = (bus.prog_len > DEPTH_V) ? DEPTH_V : bus.prog_len;
    assign last_slot   = ({1'b0, pc_q} == (len_q - 1'b1));
    // cmd_hold carries the issued word through WAIT/CAPTURE, so its opcode decides the retry
    assign cas_miss    = (cmd_hold[11:9] == 3'b111) && !bus.Z;
    assign write_ok    = (state == S_IDLE) && bus.prog_we && ({1'b0, bus.prog_waddr} < DEPTH_V);

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[bus.prog_waddr[IDX_W-1:0]] <= bus.prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_hold   <= '0;
            len_q      <= '0;
            wait_cnt   <= '0;
            pc_q       <= '0;
            retry_q    <= '0;
            cas_fail_q <= 1'b0;
            last_y_q   <= '0;
            flags_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q <= len_clamped;
                        if (len_clamped == '0) begin
                            state <= S_FINISH;
                        end else begin
                            pc_q       <= '0;
                            retry_q    <= '0;
                            cas_fail_q <= 1'b0;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cmd_hold <= cur_cmd;
                    wait_cnt <= GAP_V;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == GW'(1)) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    last_y_q <= bus.y;
                    flags_q  <= {bus.O, bus.C, bus.Z, bus.N};
                    if (cas_miss && (retry_q != RETRY_LIM)) begin
                        retry_q <= retry_q + 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        if (cas_miss) begin
                            cas_fail_q <= 1'b1;
                        end
                        retry_q <= '0;
                        if (last_slot) begin
                            state <= S_FINISH;
                        end else begin
                            pc_q  <= pc_q + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobe, busy and done decode straight from state so an async reset drops them at once
    assign bus.command    = (state == S_ISSUE) ? cur_cmd : cmd_hold;
    assign bus.syscall    = (state == S_ISSUE);
    assign bus.busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CAPTURE);
    assign bus.done       = (state == S_FINISH);
    assign bus.pc         = pc_q;
    assign bus.last_y     = last_y_q;
    assign bus.last_flags = flags_q;
    assign bus.cas_fail   = cas_fail_q;
    assign bus.retry_cnt  = retry_q;
endmodule
